// File: rtl/cr_kme_hyst_fifo_pkg.sv
// cr_kme_fifo_pkg: shared types and constants for the hysteresis FIFO
package cr_kme_fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    localparam int ERR_OVF = 1;
    localparam int ERR_UNF = 0;

endpackage

// File: rtl/cr_kme_hyst_fifo_if.sv
// cr_kme_hyst_fifo_if: write, read, status and error signals of the hysteresis FIFO
interface cr_kme_hyst_fifo_if #(
    parameter int DATA_SIZE  = 256,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_SIZE-1:0] fifo_in;
    logic                 fifo_in_valid;
    logic                 fifo_in_stall;
    logic                 fifo_in_stall_override;
    logic                 fifo_clear;
    logic [DATA_SIZE-1:0] fifo_out;
    logic                 fifo_out_valid;
    logic                 fifo_out_ack;
    logic [CW-1:0]        fifo_used_slots;
    logic [CW-1:0]        fifo_free_slots;
    logic [CW-1:0]        fifo_hwm;
    logic                 fifo_hwm_clr;
    logic                 fifo_overflow;
    logic                 fifo_underflow;
    logic [1:0]           fifo_err_sticky;
    logic                 fifo_err_clr;

    modport master (
        output fifo_in, fifo_in_valid, fifo_in_stall_override, fifo_clear,
               fifo_out_ack, fifo_hwm_clr, fifo_err_clr,
        input  fifo_in_stall, fifo_out, fifo_out_valid, fifo_used_slots,
               fifo_free_slots, fifo_hwm, fifo_overflow, fifo_underflow, fifo_err_sticky
    );

    modport slave (
        input  fifo_in, fifo_in_valid, fifo_in_stall_override, fifo_clear,
               fifo_out_ack, fifo_hwm_clr, fifo_err_clr,
        output fifo_in_stall, fifo_out, fifo_out_valid, fifo_used_slots,
               fifo_free_slots, fifo_hwm, fifo_overflow, fifo_underflow, fifo_err_sticky
    );

endinterface

// File: rtl/cr_kme_hyst_fifo_regfile.sv
// cr_kme_fifo_regfile: FIFO storage, synchronous write, asynchronous read, no reset
module cr_kme_fifo_regfile #(
    parameter int DATA_SIZE  = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

    // Write the addressed entry; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cr_kme_hyst_fifo.sv
// cr_kme_hyst_fifo: show-ahead FIFO with hysteresis stall, high-water mark and error flags
module cr_kme_hyst_fifo
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_SIZE   = 256,
    parameter int FIFO_DEPTH  = 8,
    parameter int STALL_AT    = 1,
    parameter int RESUME_AT   = 2,
    parameter bit OVERRIDE_EN = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    cr_kme_hyst_fifo_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_C  = CW'(STALL_AT);
    localparam logic [CW-1:0] RESUME_C = CW'(RESUME_AT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if (FIFO_DEPTH < 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least 2");
    end
    if (STALL_AT >= FIFO_DEPTH) begin : g_stall_chk
        $error("STALL_AT must be below FIFO_DEPTH");
    end
    if (RESUME_AT < STALL_AT) begin : g_resume_lo_chk
        $error("RESUME_AT must not be below STALL_AT");
    end
    if (RESUME_AT >= FIFO_DEPTH) begin : g_resume_hi_chk
        $error("RESUME_AT must be below FIFO_DEPTH");
    end

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] used, used_nxt, free_nxt, hwm, hwm_nxt;
    logic [1:0]    err, err_nxt, err_new;
    logic          ovf_q, unf_q;
    logic          empty, full, rd, wr, ovf, unf;
    stall_state_e  state, state_nxt;

    // A flush suppresses every read, write and error of its cycle
    assign empty = used == '0;
    assign full  = used == DEPTH_C;
    assign rd    = !bus.fifo_clear && bus.fifo_out_ack && !empty;
    assign wr    = !bus.fifo_clear && bus.fifo_in_valid && (!full || rd);
    assign ovf   = !bus.fifo_clear && bus.fifo_in_valid && full && !rd;
    assign unf   = !bus.fifo_clear && bus.fifo_out_ack && empty;

    cr_kme_fifo_regfile #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_regfile (
        .clk  (clk),
        .we   (wr),
        .waddr(wr_ptr),
        .wdata(bus.fifo_in),
        .raddr(rd_ptr),
        .rdata(bus.fifo_out)
    );

    // Post-edge occupancy drives the stall thresholds and the high-water mark
    always_comb begin
        used_nxt  = bus.fifo_clear ? '0 :
                    (wr && !rd)    ? used + CNT_ONE :
                    (rd && !wr)    ? used - CNT_ONE : used;
        free_nxt  = DEPTH_C - used_nxt;
        state_nxt = bus.fifo_clear                          ? RUN   :
                    (state == RUN   && free_nxt <= STALL_C) ? STALL :
                    (state == STALL && free_nxt >  RESUME_C) ? RUN  : state;
        hwm_nxt   = (bus.fifo_hwm_clr || used_nxt > hwm) ? used_nxt : hwm;
        err_new          = '0;
        err_new[ERR_OVF] = ovf;
        err_new[ERR_UNF] = unf;
        err_nxt   = (bus.fifo_err_clr ? 2'b00 : err) | err_new;
    end

    // Stall FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Pointers, occupancy, high-water mark and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            hwm    <= '0;
            err    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wr_ptr <= bus.fifo_clear ? '0 : !wr ? wr_ptr : (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
            rd_ptr <= bus.fifo_clear ? '0 : !rd ? rd_ptr : (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            used   <= used_nxt;
            hwm    <= hwm_nxt;
            err    <= err_nxt;
            ovf_q  <= ovf;
            unf_q  <= unf;
        end
    end

    assign bus.fifo_out_valid  = !empty;
    assign bus.fifo_used_slots = used;
    assign bus.fifo_free_slots = DEPTH_C - used;
    assign bus.fifo_hwm        = hwm;
    assign bus.fifo_overflow   = ovf_q;
    assign bus.fifo_underflow  = unf_q;
    assign bus.fifo_err_sticky = err;
    assign bus.fifo_in_stall   = (state == STALL) && !(OVERRIDE_EN && bus.fifo_in_stall_override);

endmodule

// File: tb/tb_cr_kme_hyst_fifo.sv
// tb_cr_kme_hyst_fifo: directed and random checks against a queue-based reference model
module tb_cr_kme_hyst_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [255:0] q[$];
    bit           m_stall;
    int           m_hwm;
    logic [1:0]   m_sticky;
    bit           m_ovf, m_unf, m_ovr;

    cr_kme_hyst_fifo_if #(.DATA_SIZE(256), .FIFO_DEPTH(DEPTH)) bus ();

    cr_kme_hyst_fifo #(
        .DATA_SIZE  (256),
        .FIFO_DEPTH (DEPTH),
        .STALL_AT   (1),
        .RESUME_AT  (2),
        .OVERRIDE_EN(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  256'(bus.fifo_out_valid),  256'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".data"}, bus.fifo_out, q[0]);
        chk({tag, ".used"},   256'(bus.fifo_used_slots), 256'(q.size()));
        chk({tag, ".free"},   256'(bus.fifo_free_slots), 256'(DEPTH - q.size()));
        chk({tag, ".stall"},  256'(bus.fifo_in_stall),   256'(m_stall && !m_ovr));
        chk({tag, ".hwm"},    256'(bus.fifo_hwm),        256'(m_hwm));
        chk({tag, ".ovf"},    256'(bus.fifo_overflow),   256'(m_ovf));
        chk({tag, ".unf"},    256'(bus.fifo_underflow),  256'(m_unf));
        chk({tag, ".sticky"}, 256'(bus.fifo_err_sticky), 256'(m_sticky));
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_inputs();
        bus.fifo_in                = '0;
        bus.fifo_in_valid          = 1'b0;
        bus.fifo_out_ack           = 1'b0;
        bus.fifo_clear             = 1'b0;
        bus.fifo_hwm_clr           = 1'b0;
        bus.fifo_err_clr           = 1'b0;
        bus.fifo_in_stall_override = 1'b0;
        m_ovr                      = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_stall  = 1'b0;
        m_hwm    = 0;
        m_sticky = 2'b00;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // One clock cycle: drive inputs, apply the behavioural rules, check after the edge
    task automatic cyc(input string tag, input logic v, input logic [255:0] d, input logic a,
                       input logic c = 1'b0, input logic hc = 1'b0, input logic ec = 1'b0);
        int  n;
        int  free;
        bit  rd, wr, o, u;
        bus.fifo_in                = d;
        bus.fifo_in_valid          = v;
        bus.fifo_out_ack           = a;
        bus.fifo_clear             = c;
        bus.fifo_hwm_clr           = hc;
        bus.fifo_err_clr           = ec;
        bus.fifo_in_stall_override = m_ovr;
        n  = q.size();
        rd = !c && a && n > 0;
        wr = !c && v && (n < DEPTH || rd);
        o  = !c && v && n == DEPTH && !rd;
        u  = !c && a && n == 0;
        @(posedge clk);
        if (c) q.delete();
        else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        free = DEPTH - q.size();
        if (c) m_stall = 1'b0;
        else if (!m_stall && free <= 1) m_stall = 1'b1;
        else if (m_stall && free > 2) m_stall = 1'b0;
        if (hc || q.size() > m_hwm) m_hwm = q.size();
        if (ec) m_sticky = 2'b00;
        m_sticky = m_sticky | {o, u};
        m_ovf = o;
        m_unf = u;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [255:0] d;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain with stall hysteresis
        for (int i = 1; i <= 8; i++) cyc("fill", 1'b1, 256'(i), 1'b0);
        for (int i = 0; i < 8; i++)  cyc("drain", 1'b0, '0, 1'b1);
        chk("drain.hwm8", 256'(bus.fifo_hwm), 256'(8));

        // Overflow drops data; write with ack on full is accepted
        for (int i = 0; i < 8; i++) cyc("ofill", 1'b1, rnd256(), 1'b0);
        cyc("ovf", 1'b1, 256'hAA, 1'b0);
        chk("ovf.sticky", 256'(bus.fifo_err_sticky), 256'(2'b10));
        cyc("wr_ack_full", 1'b1, 256'hBB, 1'b1);
        for (int i = 0; i < 8; i++) cyc("odrain", 1'b0, '0, 1'b1);

        // Underflow and sticky clear racing a new error
        cyc("errclr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("unf", 1'b0, '0, 1'b1);
        cyc("unf_clr", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("unf_clr.sticky", 256'(bus.fifo_err_sticky), 256'(2'b01));

        // Clear beats a same-cycle write and ack
        cyc("hwmclr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("cfill", 1'b1, rnd256(), 1'b0);
        cyc("clear", 1'b1, rnd256(), 1'b1, 1'b1);
        chk("clear.hwm5", 256'(bus.fifo_hwm), 256'(5));
        cyc("post_clear", 1'b0, '0, 1'b0);

        // Override and pointer wrap at constant occupancy
        m_ovr = 1'b1;
        for (int i = 0; i < 7; i++)  cyc("vfill", 1'b1, rnd256(), 1'b0);
        for (int i = 0; i < 20; i++) cyc("wrap", 1'b1, rnd256(), 1'b1);
        m_ovr = 1'b0;
        for (int i = 0; i < 7; i++)  cyc("vdrain", 1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            m_ovr = ($urandom_range(0, 9) == 0);
            cyc("rand", 1'($urandom_range(0, 1)), rnd256(), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 19) == 0));
        end
        m_ovr = 1'b0;

        // Asynchronous reset mid-cycle with queued data
        cyc("pre_rst_clear", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("rfill", 1'b1, rnd256(), 1'b0);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        d = 256'h55;
        cyc("post_rst_wr", 1'b1, d, 1'b0);
        chk("post_rst.head", bus.fifo_out, d);
        cyc("post_rst_rd", 1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
